// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
//   Stall/flush sequencer for the five-stage vector ASIP pipeline and the
//   single owner of pipeline-register enables and clears.
//
//   Optional feature macro: HAZARD_PERF_CNT_EN
//     defined   -> 32-bit stall-cycle and taken-branch performance counters
//     undefined -> stall_cnt_o / flush_cnt_o tied to 0, no counter flops
//
// Ports
//   clk_i, rst_i              clock (rising edge), synchronous active-high reset
//   taken_i                   branch/jump taken in EX
//   ex_mem_read_i, ex_rd_i    EX load flag and destination register
//   id_rs1_i, id_rs2_i        ID source registers
//   vec_start_i, vec_done_i   multi-cycle vector unit handshake
//   pc_en_o, if_id_en_o, id_ex_en_o              stage enables
//   if_id_clear_o, id_ex_clear_o, ex_mem_clear_o stage clears (insert NOP)
//   state_o                   RUN=00 FLUSH=01 LOADUSE=10 VECBUSY=11
//   vec_timeout_o             one-cycle pulse on vector timeout
//   stall_cnt_o, flush_cnt_o  performance counters
module pipeline_hazard_controller #(
    parameter int REG_AW       = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int LOAD_STALL   = 1,
    parameter int VEC_TIMEOUT  = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              taken_i,
    input  logic              ex_mem_read_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              vec_start_i,
    input  logic              vec_done_i,
    output logic              pc_en_o,
    output logic              if_id_en_o,
    output logic              if_id_clear_o,
    output logic              id_ex_en_o,
    output logic              id_ex_clear_o,
    output logic              ex_mem_clear_o,
    output logic [1:0]        state_o,
    output logic              vec_timeout_o,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_FLUSH   = 2'b01,
        ST_LOADUSE = 2'b10,
        ST_VECBUSY = 2'b11
    } state_t;

    localparam logic [15:0] FLUSH_INIT = 16'(FLUSH_CYCLES - 1);
    localparam logic [15:0] LU_INIT    = 16'(LOAD_STALL - 1);
    localparam logic [15:0] VEC_LAST   = 16'(VEC_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        hz;

    assign hz = ex_mem_read_i && (ex_rd_i != '0) &&
                ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pc_en_o        = 1'b1;
        if_id_en_o     = 1'b1;
        id_ex_en_o     = 1'b1;
        if_id_clear_o  = 1'b0;
        id_ex_clear_o  = 1'b0;
        ex_mem_clear_o = 1'b0;
        vec_timeout_o  = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (taken_i) begin
                    // Squash the wrong-path instructions in IF/ID and ID/EX;
                    // PC keeps moving to load the branch target.
                    if_id_clear_o = 1'b1;
                    id_ex_clear_o = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = ST_FLUSH;
                        cnt_d   = FLUSH_INIT;
                    end
                end else if (vec_start_i) begin
                    pc_en_o        = 1'b0;
                    if_id_en_o     = 1'b0;
                    id_ex_en_o     = 1'b0;
                    ex_mem_clear_o = 1'b1;
                    state_d        = ST_VECBUSY;
                    cnt_d          = '0;
                end else if (hz) begin
                    pc_en_o       = 1'b0;
                    if_id_en_o    = 1'b0;
                    id_ex_clear_o = 1'b1;
                    if (LOAD_STALL > 1) begin
                        state_d = ST_LOADUSE;
                        cnt_d   = LU_INIT;
                    end
                end
            end
            ST_FLUSH: begin
                if_id_clear_o = 1'b1;
                cnt_d         = cnt_q - 16'd1;
                if (cnt_q == 16'd1) state_d = ST_RUN;
            end
            ST_LOADUSE: begin
                pc_en_o       = 1'b0;
                if_id_en_o    = 1'b0;
                id_ex_clear_o = 1'b1;
                cnt_d         = cnt_q - 16'd1;
                if (cnt_q == 16'd1) state_d = ST_RUN;
            end
            ST_VECBUSY: begin
                pc_en_o        = 1'b0;
                if_id_en_o     = 1'b0;
                id_ex_en_o     = 1'b0;
                ex_mem_clear_o = 1'b1;
                cnt_d          = cnt_q + 16'd1;
                // The pulse is decoded from the counter alone so vec_done_i
                // never reaches an output combinationally; done only steers
                // the next state.
                if (cnt_q == VEC_LAST) vec_timeout_o = 1'b1;
                if (vec_done_i || (cnt_q == VEC_LAST)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase

        // Reset freezes the front end and drains every stage to NOP.
        if (rst_i) begin
            pc_en_o        = 1'b0;
            if_id_en_o     = 1'b0;
            id_ex_en_o     = 1'b0;
            if_id_clear_o  = 1'b1;
            id_ex_clear_o  = 1'b1;
            ex_mem_clear_o = 1'b1;
            vec_timeout_o  = 1'b0;
        end
    end

    assign state_o = rst_i ? ST_RUN : state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;
    logic        taken_acc;

    assign taken_acc = (state_q == ST_RUN) && taken_i && !rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!pc_en_o) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (taken_acc) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule
